// File: rtl/vram_scheduler.sv
// Video SRAM access scheduler: burst line fetches with priority, single-byte host
// writes through a one-entry holding register, with a run limiter so writes still get through.
module vram_scheduler #(
  parameter int AWIDTH    = 19,
  parameter int DWIDTH    = 8,
  parameter int LWIDTH    = 8,
  parameter int FETCH_RUN = 8
) (
  input  logic              MemClk,
  input  logic              MemRstN,
  input  logic              FetchReq,
  input  logic [AWIDTH-1:0] FetchAddr,
  input  logic [LWIDTH-1:0] FetchLen,
  output logic              FetchBusy,
  output logic [DWIDTH-1:0] FetchData,
  output logic              FetchValid,
  output logic              FetchDone,
  output logic              FetchErr,
  input  logic              HostValid,
  output logic              HostReady,
  input  logic [AWIDTH-1:0] HostAddr,
  input  logic [DWIDTH-1:0] HostData,
  output logic [AWIDTH-1:0] SramAddr,
  output logic [DWIDTH-1:0] SramWData,
  output logic              SramDrive,
  input  logic [DWIDTH-1:0] SramRData,
  output logic              SramWE_n,
  output logic              SramOE_n,
  output logic [2:0]        dbg_state
);

  localparam int RWIDTH = $clog2(FETCH_RUN + 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    READ     = 3'd1,
    TURN     = 3'd2,
    WR_SETUP = 3'd3,
    WR_PULSE = 3'd4,
    WR_HOLD  = 3'd5
  } state_t;

  state_t            state, state_n;
  logic [AWIDTH-1:0] addr_cnt, addr_cnt_n, rd_addr, sram_addr_n, host_addr_q;
  logic [LWIDTH-1:0] remaining, remaining_n, rd_rem;
  logic [RWIDTH-1:0] run, run_n, run_inc;
  logic [DWIDTH-1:0] host_data_q, wdata_n;
  logic              host_full, host_load, accept, accept_zero;
  logic              oe_n_n, we_n_n, drive_n;

  assign dbg_state = state;
  // Host handshake: a byte transfers on any edge where HostValid and HostReady are both high.
  assign host_load = HostValid && HostReady;

  always_comb begin
    accept      = FetchReq && !FetchBusy && (state == IDLE) && (FetchLen != '0);
    accept_zero = FetchReq && !FetchBusy && (state == IDLE) && (FetchLen == '0);
    run_inc     = (run == RWIDTH'(FETCH_RUN)) ? run : run + 1'b1;
    state_n     = state;
    case (state)
      IDLE: begin
        if (accept)                          state_n = READ;
        else if (!accept_zero && host_full)  state_n = WR_SETUP;
      end
      READ: begin
        if (remaining == '0)
          state_n = host_full ? TURN : IDLE;
        else if (host_full && run_inc == RWIDTH'(FETCH_RUN))
          state_n = TURN;
      end
      TURN: begin
        if (host_full)              state_n = WR_SETUP;
        else if (remaining != '0)   state_n = READ;
        else                        state_n = IDLE;
      end
      WR_SETUP: state_n = WR_PULSE;
      WR_PULSE: state_n = WR_HOLD;
      WR_HOLD: begin
        if (remaining != '0)  state_n = TURN;
        else if (host_full)   state_n = WR_SETUP;
        else                  state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase

    // addr_cnt/remaining describe the next read still to be issued.
    rd_addr     = accept ? FetchAddr : addr_cnt;
    rd_rem      = accept ? FetchLen : remaining;
    addr_cnt_n  = addr_cnt;
    remaining_n = remaining;
    run_n       = run;
    sram_addr_n = SramAddr;
    wdata_n     = SramWData;
    if (state == READ) run_n = run_inc;
    if (state == WR_PULSE) run_n = '0;
    if (state_n == READ) begin
      addr_cnt_n  = rd_addr + 1'b1;
      remaining_n = rd_rem - 1'b1;
      sram_addr_n = rd_addr;
    end
    if (state_n == WR_SETUP) begin
      sram_addr_n = host_addr_q;
      wdata_n     = host_data_q;
    end
    oe_n_n  = (state_n != READ);
    we_n_n  = (state_n != WR_PULSE);
    drive_n = (state_n == WR_SETUP) || (state_n == WR_PULSE) || (state_n == WR_HOLD);
  end

  always_ff @(posedge MemClk or negedge MemRstN) begin
    if (!MemRstN) begin
      state     <= IDLE;
      addr_cnt  <= '0;
      remaining <= '0;
      run       <= '0;
      SramAddr  <= '0;
      SramWData <= '0;
      SramOE_n  <= 1'b1;
      SramWE_n  <= 1'b1;
      SramDrive <= 1'b0;
    end else begin
      state     <= state_n;
      addr_cnt  <= addr_cnt_n;
      remaining <= remaining_n;
      run       <= run_n;
      SramAddr  <= sram_addr_n;
      SramWData <= wdata_n;
      SramOE_n  <= oe_n_n;
      SramWE_n  <= we_n_n;
      SramDrive <= drive_n;
    end
  end

  // HostReady rises one cycle after the register empties, and drops on the loading edge.
  always_ff @(posedge MemClk or negedge MemRstN) begin
    if (!MemRstN) begin
      host_full   <= 1'b0;
      host_addr_q <= '0;
      host_data_q <= '0;
      HostReady   <= 1'b0;
    end else begin
      HostReady <= !host_full && !host_load;
      if (host_load) begin
        host_full   <= 1'b1;
        host_addr_q <= HostAddr;
        host_data_q <= HostData;
      end else if (state == WR_PULSE) begin
        host_full <= 1'b0;
      end
    end
  end

  always_ff @(posedge MemClk or negedge MemRstN) begin
    if (!MemRstN) begin
      FetchBusy  <= 1'b0;
      FetchData  <= '0;
      FetchValid <= 1'b0;
      FetchDone  <= 1'b0;
      FetchErr   <= 1'b0;
    end else begin
      FetchValid <= (state == READ);
      if (state == READ) FetchData <= SramRData;
      FetchDone <= ((state == READ) && (remaining == '0)) || accept_zero;
      FetchErr  <= FetchReq && FetchBusy;
      if (accept)         FetchBusy <= 1'b1;
      else if (FetchDone) FetchBusy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vram_scheduler.sv
// Bench for vram_scheduler: table of fetch bursts with optional pending host writes,
// plus hand sequences for host write timing, FetchErr, zero-length fetch and async reset.
module tb_vram_scheduler;
  localparam int AW = 19;
  localparam int DW = 8;
  localparam int LW = 8;

  logic          MemClk = 1'b0;
  logic          MemRstN = 1'b0;
  logic          FetchReq = 1'b0;
  logic [AW-1:0] FetchAddr = '0;
  logic [LW-1:0] FetchLen = '0;
  logic          FetchBusy, FetchValid, FetchDone, FetchErr;
  logic [DW-1:0] FetchData;
  logic          HostValid = 1'b0;
  logic          HostReady;
  logic [AW-1:0] HostAddr = '0;
  logic [DW-1:0] HostData = '0;
  logic [AW-1:0] SramAddr;
  logic [DW-1:0] SramWData, SramRData;
  logic          SramDrive, SramWE_n, SramOE_n;
  logic [2:0]    dbg_state;

  vram_scheduler #(.AWIDTH(AW), .DWIDTH(DW), .LWIDTH(LW), .FETCH_RUN(8)) dut (
    .MemClk(MemClk), .MemRstN(MemRstN),
    .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchLen(FetchLen),
    .FetchBusy(FetchBusy), .FetchData(FetchData), .FetchValid(FetchValid),
    .FetchDone(FetchDone), .FetchErr(FetchErr),
    .HostValid(HostValid), .HostReady(HostReady), .HostAddr(HostAddr), .HostData(HostData),
    .SramAddr(SramAddr), .SramWData(SramWData), .SramDrive(SramDrive),
    .SramRData(SramRData), .SramWE_n(SramWE_n), .SramOE_n(SramOE_n),
    .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #10 MemClk = ~MemClk;
  int cyc = 0;
  always @(posedge MemClk) cyc <= cyc + 1;

  initial begin
    #1000000;
    $display("FAIL watchdog: got no summary, required finish within 1 ms");
    $fatal(1, "watchdog");
  end

  // SRAM model: read data is a fixed function of the address.
  function automatic logic [DW-1:0] pattern(input logic [AW-1:0] a);
    return a[7:0] ^ 8'h3C ^ {5'b0, a[18:16]};
  endfunction
  assign SramRData = pattern(SramAddr);

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  logic [DW-1:0] exp_q[$];
  logic [AW-1:0] rd_addrs[$];
  int            rd_cyc[$];
  logic [AW-1:0] wr_addrs[$];
  logic [DW-1:0] wr_datas[$];
  int            wr_cyc[$];
  int            wr_rbw[$];
  int            valid_cnt, done_cnt, done_v_cnt, err_cnt;
  logic          prev_oe_low = 1'b0;

  always @(negedge MemClk) begin
    chk("strobe_overlap", {31'b0, (!SramOE_n && !SramWE_n)}, 0);
    chk("drive_during_read", {31'b0, (SramDrive && !SramOE_n)}, 0);
    if (FetchValid) begin
      valid_cnt++;
      chk("valid_latency", {31'b0, prev_oe_low}, 1);
      chk("valid_without_read", {31'b0, (exp_q.size() > 0)}, 1);
      if (exp_q.size() > 0) chk("fetch_data", FetchData, exp_q.pop_front());
    end
    if (FetchDone) begin
      done_cnt++;
      if (FetchValid) done_v_cnt++;
    end
    if (FetchErr) err_cnt++;
    if (!SramOE_n) begin
      rd_addrs.push_back(SramAddr);
      rd_cyc.push_back(cyc);
      exp_q.push_back(pattern(SramAddr));
    end
    if (!SramWE_n) begin
      wr_addrs.push_back(SramAddr);
      wr_datas.push_back(SramWData);
      wr_cyc.push_back(cyc);
      wr_rbw.push_back(rd_addrs.size());
      chk("drive_on_we", {31'b0, SramDrive}, 1);
    end
    prev_oe_low = !SramOE_n;
  end

  task automatic clear_mon();
    exp_q.delete(); rd_addrs.delete(); rd_cyc.delete();
    wr_addrs.delete(); wr_datas.delete(); wr_cyc.delete(); wr_rbw.delete();
    valid_cnt = 0; done_cnt = 0; done_v_cnt = 0; err_cnt = 0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    do begin
      @(negedge MemClk);
      n++;
    end while (!(HostReady && !SramDrive && !FetchBusy) && n < 100);
    chk({name, "_idle_reached"}, {31'b0, (n < 100)}, 1);
    repeat (2) @(negedge MemClk);
    #1;
  endtask

  task automatic host_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    @(negedge MemClk);
    HostValid = 1'b1; HostAddr = a; HostData = d;
    @(posedge MemClk);
    #1 HostValid = 1'b0;
    wait_idle("host_write");
  endtask

  task automatic launch_fetch(input logic [AW-1:0] a, input logic [LW-1:0] l, input bit host,
                              input logic [AW-1:0] ha, input logic [DW-1:0] hd,
                              output int launch);
    @(negedge MemClk);
    FetchReq = 1'b1; FetchAddr = a; FetchLen = l;
    if (host) begin
      HostValid = 1'b1; HostAddr = ha; HostData = hd;
    end
    @(posedge MemClk);
    #1;
    FetchReq = 1'b0; HostValid = 1'b0;
    launch = cyc;
  endtask

  task automatic wait_done(input string name);
    int  n = 0;
    bit  got = 0;
    while (!got && n < 300) begin
      @(negedge MemClk);
      n++;
      if (FetchDone) got = 1;
    end
    chk({name, "_done_seen"}, {31'b0, got}, 1);
    if (got) begin
      chk({name, "_busy_at_done"}, {31'b0, FetchBusy}, 1);
      @(negedge MemClk);
      chk({name, "_busy_after_done"}, {31'b0, FetchBusy}, 0);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic [LW-1:0] len;
    bit            host;
    logic [AW-1:0] haddr;
    logic [DW-1:0] hdata;
    int            exp_rbw;   // reads issued before the inserted write
    logic [AW-1:0] exp_last;  // address of the final read
  } vec_t;

  vec_t vecs[6];

  task automatic run_vec(input int idx, input vec_t v);
    int            launch, span;
    logic [AW-1:0] ea;
    string         p;
    p = $sformatf("v%0d", idx);
    if (v.host) host_write(19'h00F00, 8'h11);
    clear_mon();
    launch_fetch(v.addr, v.len, v.host, v.haddr, v.hdata, launch);
    wait_done(p);
    wait_idle(p);
    chk({p, "_read_count"}, rd_addrs.size(), int'(v.len));
    for (int i = 0; i < int'(v.len) && i < rd_addrs.size(); i++) begin
      ea = v.addr + AW'(i);
      chk($sformatf("%s_addr%0d", p, i), rd_addrs[i], ea);
    end
    if (rd_addrs.size() > 0) begin
      chk({p, "_first_read_cycle"}, rd_cyc[0], launch);
      chk({p, "_last_addr"}, rd_addrs[$], v.exp_last);
      span = int'(v.len) - 1 + ((v.host && int'(v.len) > v.exp_rbw) ? 5 : 0);
      chk({p, "_read_span"}, rd_cyc[$] - rd_cyc[0], span);
    end
    chk({p, "_valid_count"}, valid_cnt, int'(v.len));
    chk({p, "_done_count"}, done_cnt, 1);
    chk({p, "_done_with_valid"}, done_v_cnt, 1);
    chk({p, "_exp_q_drained"}, exp_q.size(), 0);
    chk({p, "_write_count"}, wr_addrs.size(), v.host ? 1 : 0);
    if (v.host && wr_addrs.size() > 0) begin
      chk({p, "_wr_addr"}, wr_addrs[0], v.haddr);
      chk({p, "_wr_data"}, wr_datas[0], v.hdata);
      chk({p, "_reads_before_wr"}, wr_rbw[0], v.exp_rbw);
      if (rd_cyc.size() >= v.exp_rbw && v.exp_rbw > 0)
        chk({p, "_wr_pulse_gap"}, wr_cyc[0] - rd_cyc[v.exp_rbw-1], 3);
    end
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int n;
    bit seen;
    int launch;

    vecs[0] = '{19'h00100,  8'd4, 1'b0, 19'h00000, 8'h00, -1, 19'h00103};
    vecs[1] = '{19'h7FFFE,  8'd3, 1'b0, 19'h00000, 8'h00, -1, 19'h00000};
    vecs[2] = '{19'h12345, 8'd20, 1'b1, 19'h00ABC, 8'h3C,  8, 19'h12358};
    vecs[3] = '{19'h00010,  8'd8, 1'b1, 19'h00200, 8'hC3,  8, 19'h00017};
    vecs[4] = '{19'h40000,  8'd1, 1'b0, 19'h00000, 8'h00, -1, 19'h40000};
    vecs[5] = '{19'h7FFF0, 8'd30, 1'b1, 19'h1FFFF, 8'h81,  8, 19'h0000D};

    // reset state
    repeat (3) @(negedge MemClk);
    chk("rst_we_n", {31'b0, SramWE_n}, 1);
    chk("rst_oe_n", {31'b0, SramOE_n}, 1);
    chk("rst_drive", {31'b0, SramDrive}, 0);
    chk("rst_addr", SramAddr, 0);
    chk("rst_wdata", SramWData, 0);
    chk("rst_busy", {31'b0, FetchBusy}, 0);
    chk("rst_valid", {31'b0, FetchValid}, 0);
    chk("rst_done", {31'b0, FetchDone}, 0);
    chk("rst_err", {31'b0, FetchErr}, 0);
    chk("rst_fdata", FetchData, 0);
    chk("rst_host_ready", {31'b0, HostReady}, 0);
    MemRstN = 1'b1;
    @(negedge MemClk);
    chk("rel_host_ready", {31'b0, HostReady}, 1);
    #1;

    // idle host write, cycle by cycle
    clear_mon();
    @(negedge MemClk);
    HostValid = 1'b1; HostAddr = 19'h7FFFF; HostData = 8'hA5;
    @(negedge MemClk);
    HostValid = 1'b0;
    chk("hw_ready_after_load", {31'b0, HostReady}, 0);
    chk("hw_idle_we", {31'b0, SramWE_n}, 1);
    chk("hw_idle_drive", {31'b0, SramDrive}, 0);
    @(negedge MemClk);
    chk("hw_setup_drive", {31'b0, SramDrive}, 1);
    chk("hw_setup_we", {31'b0, SramWE_n}, 1);
    chk("hw_setup_addr", SramAddr, 19'h7FFFF);
    chk("hw_setup_data", SramWData, 8'hA5);
    @(negedge MemClk);
    chk("hw_pulse_we", {31'b0, SramWE_n}, 0);
    chk("hw_pulse_addr", SramAddr, 19'h7FFFF);
    chk("hw_pulse_data", SramWData, 8'hA5);
    @(negedge MemClk);
    chk("hw_hold_we", {31'b0, SramWE_n}, 1);
    chk("hw_hold_drive", {31'b0, SramDrive}, 1);
    chk("hw_hold_ready", {31'b0, HostReady}, 0);
    chk("hw_hold_addr", SramAddr, 19'h7FFFF);
    @(negedge MemClk);
    chk("hw_after_ready", {31'b0, HostReady}, 1);
    chk("hw_after_drive", {31'b0, SramDrive}, 0);
    repeat (2) @(negedge MemClk);
    #1;
    chk("hw_we_pulses", wr_addrs.size(), 1);

    // table-driven fetch bursts
    for (int i = 0; i < 6; i++) run_vec(i, vecs[i]);

    // FetchReq while busy
    clear_mon();
    launch_fetch(19'h00200, 8'd6, 1'b0, 19'h0, 8'h0, launch);
    @(negedge MemClk);
    FetchReq = 1'b1; FetchAddr = 19'h55555; FetchLen = 8'd9;
    @(negedge MemClk);
    FetchReq = 1'b0;
    chk("err_pulse", {31'b0, FetchErr}, 1);
    @(negedge MemClk);
    chk("err_one_cycle", {31'b0, FetchErr}, 0);
    wait_done("err");
    wait_idle("err");
    chk("err_count", err_cnt, 1);
    chk("err_read_count", rd_addrs.size(), 6);
    if (rd_addrs.size() > 0) chk("err_last_addr", rd_addrs[$], 19'h00205);

    // zero-length fetch
    clear_mon();
    @(negedge MemClk);
    FetchReq = 1'b1; FetchAddr = 19'h00100; FetchLen = 8'd0;
    @(negedge MemClk);
    FetchReq = 1'b0;
    chk("len0_done", {31'b0, FetchDone}, 1);
    chk("len0_busy", {31'b0, FetchBusy}, 0);
    @(negedge MemClk);
    chk("len0_done_pulse", {31'b0, FetchDone}, 0);
    repeat (3) @(negedge MemClk);
    #1;
    chk("len0_reads", rd_addrs.size(), 0);
    chk("len0_done_count", done_cnt, 1);
    chk("len0_valid_count", valid_cnt, 0);

    // async reset during WR_PULSE
    clear_mon();
    @(negedge MemClk);
    HostValid = 1'b1; HostAddr = 19'h01234; HostData = 8'h77;
    @(posedge MemClk);
    #1 HostValid = 1'b0;
    n = 0; seen = 0;
    while (!seen && n < 10) begin
      @(negedge MemClk);
      n++;
      if (!SramWE_n) seen = 1;
    end
    chk("rstw_pulse_seen", {31'b0, seen}, 1);
    #2 MemRstN = 1'b0;
    #1;
    chk("rstw_we_n", {31'b0, SramWE_n}, 1);
    chk("rstw_drive", {31'b0, SramDrive}, 0);
    chk("rstw_ready", {31'b0, HostReady}, 0);
    chk("rstw_addr", SramAddr, 0);
    @(negedge MemClk);
    MemRstN = 1'b1;
    @(negedge MemClk);
    chk("rstw_rel_ready", {31'b0, HostReady}, 1);
    chk("rstw_rel_we_n", {31'b0, SramWE_n}, 1);
    chk("rstw_rel_oe_n", {31'b0, SramOE_n}, 1);
    chk("rstw_rel_drive", {31'b0, SramDrive}, 0);
    repeat (6) @(negedge MemClk);
    #1;
    chk("rstw_no_resume", wr_addrs.size(), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
